// File: rtl/led_group_ctrl.sv
// Button-driven selector mirroring one 4-bit switch group onto its LEDs, with freeze (hold).
// Buttons are synchronized, debounced, edge-detected and arbitrated lowest-index-first.
module led_group_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sw,
    input  logic [3:0]  push_button,
    output logic [15:0] led,
    output logic [1:0]  active_group,
    output logic        group_valid,
    output logic        hold
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_HOLD} state_t;

    logic [3:0]          s1_q, s2_q;
    logic [3:0]          db_q, db_d, db_dly_q;
    logic [3:0][CW-1:0]  cnt_q, cnt_d;
    logic [3:0]          press;
    logic                press_any;
    logic [1:0]          press_idx;

    state_t              state_q;
    logic [1:0]          grp_q;
    logic                group_valid_q, hold_q;
    logic [15:0]         led_q;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            db_d[i]  = db_q[i];
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    db_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            db_q     <= '0;
            db_dly_q <= '0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= push_button;
            s2_q     <= s1_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            cnt_q    <= cnt_d;
        end
    end

    // Rising edges only; simultaneous presses resolve to the lowest index, others dropped.
    assign press = db_q & ~db_dly_q;

    always_comb begin
        press_any = |press;
        press_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (press[i]) press_idx = 2'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grp_q         <= 2'd0;
            group_valid_q <= 1'b0;
            hold_q        <= 1'b0;
        end else if (press_any) begin
            group_valid_q <= 1'b1;
            grp_q         <= press_idx;
            if (state_q == ST_ACTIVE && press_idx == grp_q) begin
                state_q <= ST_HOLD;
                hold_q  <= 1'b1;
            end else begin
                state_q <= ST_ACTIVE;
                hold_q  <= 1'b0;
            end
        end
    end

    // Other groups' bits are always zero while ACTIVE, so switching group clears the old one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q <= '0;
        end else begin
            case (state_q)
                ST_ACTIVE: led_q <= sw & (16'h000F << {grp_q, 2'b00});
                ST_HOLD:   led_q <= led_q;
                default:   led_q <= '0;
            endcase
        end
    end

    assign led          = led_q;
    assign active_group = grp_q;
    assign group_valid  = group_valid_q;
    assign hold         = hold_q;

endmodule

// File: tb/tb_led_group_ctrl.sv
// Randomized and directed bench for led_group_ctrl against a history-based reference model.
module tb_led_group_ctrl;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw;
    logic [3:0]  push_button;
    logic [15:0] led;
    logic [1:0]  active_group;
    logic        group_valid;
    logic        hold;

    int n_tests = 0;
    int n_fail  = 0;

    led_group_ctrl #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk          (clk),
        .rst          (rst),
        .sw           (sw),
        .push_button  (push_button),
        .led          (led),
        .active_group (active_group),
        .group_valid  (group_valid),
        .hold         (hold)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 active, 2 hold.
    int          m_mode;
    int          m_grp;
    logic [15:0] m_led;
    logic [3:0]  m_db;
    logic [3:0]  m_press;
    logic [3:0]  rawh[$];
    logic [3:0]  seenh[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_mode  = 0;
        m_grp   = 0;
        m_led   = '0;
        m_db    = '0;
        m_press = '0;
        rawh.delete();
        seenh.delete();
    endtask

    task automatic model_edge();
        logic [15:0] nled;
        logic [3:0]  seen, rise, past;
        int          n, sz, p;
        bit          all_diff;
        if (rst) begin
            model_clear();
            return;
        end
        nled = '0;
        if (m_mode == 1) nled[m_grp*4 +: 4] = sw[m_grp*4 +: 4];
        else if (m_mode == 2) nled = m_led;
        if (m_press != 4'b0) begin
            p = 0;
            for (int i = 3; i >= 0; i--) if (m_press[i]) p = i;
            if (m_mode == 1 && p == m_grp) m_mode = 2;
            else m_mode = 1;
            m_grp = p;
        end
        // Debounced level follows the synchronized input once it has disagreed for DEB edges in a row.
        rawh.push_back(push_button);
        n = rawh.size();
        seen = (n >= 3) ? rawh[n-3] : 4'b0;
        seenh.push_back(seen);
        sz = seenh.size();
        rise = '0;
        for (int i = 0; i < 4; i++) begin
            if (sz >= DEB) begin
                all_diff = 1'b1;
                for (int k = 1; k <= DEB; k++) begin
                    past = seenh[sz-k];
                    if (past[i] == m_db[i]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_db[i] = ~m_db[i];
                    if (m_db[i]) rise[i] = 1'b1;
                end
            end
        end
        m_press = rise;
        m_led   = nled;
    endtask

    task automatic check_model();
        chk("led", 32'(led), 32'(m_led));
        chk("active_group", 32'(active_group), 32'(m_grp));
        chk("group_valid", 32'(group_valid), 32'(m_mode != 0));
        chk("hold", 32'(hold), 32'(m_mode == 2));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press(input logic [3:0] b, input int hi, input int lo);
        push_button = b;
        steps(hi);
        push_button = 4'b0;
        steps(lo);
    endtask

    task automatic async_reset(input int edges);
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_group_valid", 32'(group_valid), 32'h0);
        chk("rst_hold", 32'(hold), 32'h0);
        steps(edges);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sw = '0;
        push_button = '0;
        model_clear();
        #1;
        check_model();
        steps(2);
        #2;
        rst = 1'b0;

        // Group 1 selection latency and live switch tracking.
        sw = 16'hA5C3;
        push_button = 4'b0010;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (e == 6) chk("sel_not_yet", 32'(group_valid), 32'h0);
            if (e == 7) begin
                chk("sel_group", 32'(active_group), 32'h1);
                chk("sel_valid", 32'(group_valid), 32'h1);
            end
            if (e == 8) chk("sel_led", 32'(led), 32'h00C0);
        end
        push_button = 4'b0;
        sw = 16'hA533;
        step();
        chk("sw_track", 32'(led), 32'h0030);
        steps(8);

        // Short glitch ignored, DEB-long pulse accepted.
        press(4'b0100, 3, 10);
        chk("glitch_ignored", 32'(active_group), 32'h1);
        press(4'b0100, 4, 10);
        chk("pulse_accepted", 32'(active_group), 32'h2);

        // Simultaneous presses: lowest wins; held loser never fires.
        push_button = 4'b0101;
        steps(10);
        chk("arb_low", 32'(active_group), 32'h0);
        push_button = 4'b0100;
        steps(12);
        chk("arb_loser_held", 32'(active_group), 32'h0);
        chk("arb_not_hold", 32'(hold), 32'h0);
        press(4'b0000, 1, 10);

        // Freeze and unfreeze group 3.
        sw = 16'h9000;
        press(4'b1000, 8, 10);
        chk("g3_led", 32'(led), 32'h9000);
        press(4'b1000, 8, 10);
        chk("g3_hold", 32'(hold), 32'h1);
        sw = 16'h0000;
        steps(3);
        chk("g3_frozen", 32'(led), 32'h9000);
        press(4'b1000, 8, 10);
        chk("g3_unhold", 32'(hold), 32'h0);
        chk("g3_live", 32'(led), 32'h0000);

        // From HOLD(3) to group 1, then held through reset.
        sw = 16'hF0F0;
        steps(2);
        press(4'b1000, 8, 10);
        chk("g3_hold2", 32'(hold), 32'h1);
        push_button = 4'b0010;
        steps(10);
        chk("hold_to_g1", 32'(active_group), 32'h1);
        chk("g3_cleared", 32'(led), 32'h00F0);
        async_reset(2);
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e == 6) chk("post_rst_idle", 32'(group_valid), 32'h0);
            if (e == 7) begin
                chk("post_rst_group", 32'(active_group), 32'h1);
                chk("post_rst_valid", 32'(group_valid), 32'h1);
            end
        end
        push_button = 4'b0;
        steps(10);

        // Randomized traffic.
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 39) == 0) begin
                async_reset($urandom_range(1, 3));
            end else begin
                push_button = 4'($urandom) & 4'($urandom);
                if ($urandom_range(0, 3) == 0) sw = 16'($urandom);
                steps($urandom_range(1, 12));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
